// File: rtl/ddc_src_arb_if.sv
// Stream bundle shared by the four capture sources, the source arbiter and the DDC input.
interface ddc_src_arb_if;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [127:0] s_tdata;
    logic [3:0]   s_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  m_tdata;
    logic         m_tlast;
    logic [1:0]   m_tid;

    // master: arbiter view (drives the DDC stream and the source readies)
    modport master (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );
endinterface

// File: rtl/ddc_src_arb.sv
// Frame-granular round-robin arbiter feeding the DDC input stream from four capture sources,
// with post-reset hold-off, stalled-frame timeout and frame/error status.
module ddc_src_arb #(
    parameter int U_DLY   = 1,
    parameter int HOLDOFF = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          rst_n,
    input  logic          axis_clk,
    input  logic [3:0]    src_en,
    ddc_src_arb_if.master bus,
    output logic          busy,
    output logic [15:0]   frame_cnt,
    output logic          timeout_err,
    input  logic          err_clr
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    if (TIMEOUT < 2 || TIMEOUT > 65535 || HOLDOFF < 1 || U_DLY < 0) begin : g_bad_param
        $error("ddc_src_arb: parameter out of range");
    end

    typedef enum logic [1:0] {ST_HOLD, ST_ARB, ST_XFER} state_t;

    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic [1:0]    r_grant;
    logic [1:0]    r_last;
    logic [15:0]   r_to_cnt;
    logic [15:0]   r_frame_cnt;
    logic          r_to_err;

    logic [3:0]    w_req;
    logic [1:0]    w_next;
    logic          w_xfer;
    logic          w_hs;
    logic          w_abort;

    always_comb begin
        w_req  = src_en & bus.s_tvalid;
        w_next = r_last;
        // Scan offsets 4,3,2,1 so the nearest source after the last grant is written last.
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_req[r_last + 2'(4 - i)]) begin
                w_next = r_last + 2'(4 - i);
            end
        end

        w_xfer       = (r_state == ST_XFER);
        bus.m_tvalid = w_xfer & bus.s_tvalid[r_grant];
        bus.m_tlast  = w_xfer & bus.s_tlast[r_grant];
        bus.m_tdata  = w_xfer ? bus.s_tdata[32*r_grant +: 32] : '0;
        bus.m_tid    = w_xfer ? r_grant : '0;
        bus.s_tready = '0;
        if (w_xfer) begin
            bus.s_tready[r_grant] = bus.m_tready;
        end

        w_hs        = bus.m_tvalid & bus.m_tready;
        w_abort     = w_xfer & ~w_hs & (r_to_cnt == 16'(TIMEOUT - 1));
        busy        = w_xfer;
        frame_cnt   = r_frame_cnt;
        timeout_err = r_to_err;
    end

    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_grant     <= '0;
            r_last      <= 2'd3;
            r_to_cnt    <= '0;
            r_frame_cnt <= '0;
            r_to_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HW'(HOLDOFF - 1)) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                ST_ARB: begin
                    if (|w_req) begin
                        r_grant  <= w_next;
                        r_last   <= w_next;
                        r_to_cnt <= '0;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_hs) begin
                        r_to_cnt <= '0;
                        if (bus.m_tlast) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= ST_ARB;
                        end
                    end else if (w_abort) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_HOLD;
            endcase

            if (w_abort) begin
                r_to_err <= 1'b1;
            end else if (err_clr) begin
                r_to_err <= 1'b0;
            end
        end
    end
endmodule
